// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, branch resolve, EX/MEM register.
// Two-register latency; stall_e holds ID/EX and drops a bubble into EX/MEM, flush_e bubbles ID/EX.
module ex_stage #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic             id_valid,
    input  logic [2:0]       id_alucontrol,
    input  logic             id_alusrc,
    input  logic             id_regwrite,
    input  logic             id_memwrite,
    input  logic             id_memtoreg,
    input  logic             id_branch,
    input  logic             id_bne,
    input  logic [WIDTH-1:0] id_rd1,
    input  logic [WIDTH-1:0] id_rd2,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [RADDR-1:0] id_writereg,
    input  logic [WIDTH-1:0] id_pcplus4,
    input  logic [1:0]       fwd_a,
    input  logic [1:0]       fwd_b,
    input  logic [WIDTH-1:0] mem_fwd,
    input  logic [WIDTH-1:0] wb_fwd,
    output logic [WIDTH-1:0] ex_rs_val_q,
    output logic             mem_valid,
    output logic [WIDTH-1:0] mem_aluout,
    output logic [WIDTH-1:0] mem_writedata,
    output logic [RADDR-1:0] mem_writereg,
    output logic             mem_regwrite,
    output logic             mem_memwrite,
    output logic             mem_memtoreg,
    output logic             mem_pcsrc,
    output logic [WIDTH-1:0] mem_pcbranch,
    output logic             mem_illegal
);

    logic             r_e_valid, r_e_alusrc, r_e_regwrite, r_e_memwrite, r_e_memtoreg;
    logic             r_e_branch, r_e_bne;
    logic [2:0]       r_e_alucontrol;
    logic [WIDTH-1:0] r_e_rd1, r_e_rd2, r_e_imm, r_e_pcplus4;
    logic [RADDR-1:0] r_e_writereg;

    logic             r_m_valid, r_m_regwrite, r_m_memwrite, r_m_memtoreg, r_m_pcsrc, r_m_illegal;
    logic [WIDTH-1:0] r_m_aluout, r_m_writedata, r_m_pcbranch;
    logic [RADDR-1:0] r_m_writereg;

    logic [WIDTH-1:0] w_srca, w_srcb, w_writedata, w_result, w_pcbranch;
    logic             w_zero, w_taken, w_illegal;

    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            r_e_valid      <= 1'b0;
            r_e_alucontrol <= '0;
            r_e_alusrc     <= 1'b0;
            r_e_regwrite   <= 1'b0;
            r_e_memwrite   <= 1'b0;
            r_e_memtoreg   <= 1'b0;
            r_e_branch     <= 1'b0;
            r_e_bne        <= 1'b0;
            r_e_rd1        <= '0;
            r_e_rd2        <= '0;
            r_e_imm        <= '0;
            r_e_writereg   <= '0;
            r_e_pcplus4    <= '0;
        end else if (!stall_e) begin
            r_e_valid      <= id_valid;
            r_e_alucontrol <= id_alucontrol;
            r_e_alusrc     <= id_alusrc;
            r_e_regwrite   <= id_regwrite;
            r_e_memwrite   <= id_memwrite;
            r_e_memtoreg   <= id_memtoreg;
            r_e_branch     <= id_branch;
            r_e_bne        <= id_bne;
            r_e_rd1        <= id_rd1;
            r_e_rd2        <= id_rd2;
            r_e_imm        <= id_imm;
            r_e_writereg   <= id_writereg;
            r_e_pcplus4    <= id_pcplus4;
        end
    end

    // 2'b11 falls back to the register value, same as 2'b00.
    always_comb begin
        case (fwd_a)
            2'b10:   w_srca = mem_fwd;
            2'b01:   w_srca = wb_fwd;
            default: w_srca = r_e_rd1;
        endcase
        case (fwd_b)
            2'b10:   w_writedata = mem_fwd;
            2'b01:   w_writedata = wb_fwd;
            default: w_writedata = r_e_rd2;
        endcase
        w_srcb = r_e_alusrc ? r_e_imm : w_writedata;
    end

    always_comb begin
        w_illegal = 1'b0;
        case (r_e_alucontrol)
            3'b010:  w_result = w_srca + w_srcb;
            3'b110:  w_result = w_srca - w_srcb;
            3'b000:  w_result = w_srca & w_srcb;
            3'b001:  w_result = w_srca | w_srcb;
            3'b011:  w_result = w_srca ^ w_srcb;
            3'b111:  w_result = {{(WIDTH-1){1'b0}}, ($signed(w_srca) < $signed(w_srcb))};
            default: begin
                w_result  = '0;
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_zero      = (w_result == '0);
    assign w_taken     = r_e_valid & r_e_branch & (w_zero ^ r_e_bne);
    assign w_pcbranch  = r_e_pcplus4 + (r_e_imm << 2);
    assign ex_rs_val_q = w_srca;

    always_ff @(posedge clk) begin
        if (reset || stall_e) begin
            r_m_valid     <= 1'b0;
            r_m_aluout    <= '0;
            r_m_writedata <= '0;
            r_m_writereg  <= '0;
            r_m_regwrite  <= 1'b0;
            r_m_memwrite  <= 1'b0;
            r_m_memtoreg  <= 1'b0;
            r_m_pcsrc     <= 1'b0;
            r_m_pcbranch  <= '0;
            r_m_illegal   <= 1'b0;
        end else begin
            r_m_valid     <= r_e_valid;
            r_m_aluout    <= w_result;
            r_m_writedata <= w_writedata;
            r_m_writereg  <= r_e_writereg;
            r_m_regwrite  <= r_e_valid & r_e_regwrite;
            r_m_memwrite  <= r_e_valid & r_e_memwrite;
            r_m_memtoreg  <= r_e_valid & r_e_memtoreg;
            r_m_pcsrc     <= w_taken;
            r_m_pcbranch  <= w_pcbranch;
            r_m_illegal   <= r_e_valid & w_illegal;
        end
    end

    assign mem_valid     = r_m_valid;
    assign mem_aluout    = r_m_aluout;
    assign mem_writedata = r_m_writedata;
    assign mem_writereg  = r_m_writereg;
    assign mem_regwrite  = r_m_regwrite;
    assign mem_memwrite  = r_m_memwrite;
    assign mem_memtoreg  = r_m_memtoreg;
    assign mem_pcsrc     = r_m_pcsrc;
    assign mem_pcbranch  = r_m_pcbranch;
    assign mem_illegal   = r_m_illegal;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against an instruction-level model of the two pipeline slots.
module tb_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [2:0]  ctl;
        logic        alusrc, rw, mw, mtr, br, bne;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  wr;
        logic [31:0] pc4;
    } instr_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu, wd;
        logic [4:0]  wr;
        logic        rw, mw, mtr, pcsrc;
        logic [31:0] pcbr;
        logic        ill;
    } out_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1, stall_e = 1'b0, flush_e = 1'b0;
    logic [1:0]  fwd_a = 2'b00, fwd_b = 2'b00;
    logic [31:0] mem_fwd = '0, wb_fwd = '0;
    instr_t      din = '0;

    logic [31:0] ex_rs_val_q, mem_aluout, mem_writedata, mem_pcbranch;
    logic [4:0]  mem_writereg;
    logic        mem_valid, mem_regwrite, mem_memwrite, mem_memtoreg, mem_pcsrc, mem_illegal;

    int     n_tests = 0, n_fail = 0;
    bit     chk_en = 1'b0;
    instr_t ide = '0;     // model of the instruction sitting in EX
    out_t   exp_o = '0;   // model of the EX/MEM payload

    always #5 clk = ~clk;

    ex_stage #(.WIDTH(32), .RADDR(5)) dut (
        .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
        .id_valid(din.valid), .id_alucontrol(din.ctl), .id_alusrc(din.alusrc),
        .id_regwrite(din.rw), .id_memwrite(din.mw), .id_memtoreg(din.mtr),
        .id_branch(din.br), .id_bne(din.bne), .id_rd1(din.rd1), .id_rd2(din.rd2),
        .id_imm(din.imm), .id_writereg(din.wr), .id_pcplus4(din.pc4),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
        .ex_rs_val_q(ex_rs_val_q), .mem_valid(mem_valid), .mem_aluout(mem_aluout),
        .mem_writedata(mem_writedata), .mem_writereg(mem_writereg),
        .mem_regwrite(mem_regwrite), .mem_memwrite(mem_memwrite),
        .mem_memtoreg(mem_memtoreg), .mem_pcsrc(mem_pcsrc),
        .mem_pcbranch(mem_pcbranch), .mem_illegal(mem_illegal)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] pick(logic [31:0] regv, logic [1:0] sel,
                                         logic [31:0] mf, logic [31:0] wf);
        if (sel == 2'b10) return mf;
        if (sel == 2'b01) return wf;
        return regv;
    endfunction

    function automatic out_t ex_model(instr_t e, logic [1:0] fa, logic [1:0] fb,
                                      logic [31:0] mf, logic [31:0] wf);
        out_t o;
        logic [31:0] a, b, wd, r;
        a  = pick(e.rd1, fa, mf, wf);
        wd = pick(e.rd2, fb, mf, wf);
        b  = e.alusrc ? e.imm : wd;
        case (e.ctl)
            3'b010:  r = a + b;
            3'b110:  r = a - b;
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b011:  r = a ^ b;
            3'b111:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        o.valid = e.valid;
        o.alu   = r;
        o.wd    = wd;
        o.wr    = e.wr;
        o.rw    = e.valid & e.rw;
        o.mw    = e.valid & e.mw;
        o.mtr   = e.valid & e.mtr;
        o.pcsrc = e.valid & e.br & ((r == 32'd0) ^ e.bne);
        o.pcbr  = e.pc4 + (e.imm << 2);
        o.ill   = e.valid & ((e.ctl == 3'b100) || (e.ctl == 3'b101));
        return o;
    endfunction

    // Advance one edge and let the model follow the same edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) begin
            exp_o = '0;
            ide   = '0;
        end else begin
            exp_o = stall_e ? '0 : ex_model(ide, fwd_a, fwd_b, mem_fwd, wb_fwd);
            if (flush_e)       ide = '0;
            else if (!stall_e) ide = din;
        end
        chk_en = 1'b1;
    endtask

    function automatic instr_t op(logic [2:0] ctl, logic [31:0] rd1, logic [31:0] rd2);
        instr_t t;
        t = '0;
        t.valid = 1'b1;
        t.ctl = ctl;
        t.rd1 = rd1;
        t.rd2 = rd2;
        return t;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", {31'd0, mem_valid}, {31'd0, exp_o.valid});
            chk("m_aluout", mem_aluout, exp_o.alu);
            chk("m_writedata", mem_writedata, exp_o.wd);
            chk("m_writereg", {27'd0, mem_writereg}, {27'd0, exp_o.wr});
            chk("m_regwrite", {31'd0, mem_regwrite}, {31'd0, exp_o.rw});
            chk("m_memwrite", {31'd0, mem_memwrite}, {31'd0, exp_o.mw});
            if (exp_o.valid) chk("m_memtoreg", {31'd0, mem_memtoreg}, {31'd0, exp_o.mtr});
            chk("m_pcsrc", {31'd0, mem_pcsrc}, {31'd0, exp_o.pcsrc});
            chk("m_pcbranch", mem_pcbranch, exp_o.pcbr);
            chk("m_illegal", {31'd0, mem_illegal}, {31'd0, exp_o.ill});
            chk("m_rs_val", ex_rs_val_q, pick(ide.rd1, fwd_a, mem_fwd, wb_fwd));
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_regwrite", {31'd0, mem_regwrite}, 32'd0);
        chk("rst_aluout", mem_aluout, 32'd0);
        reset = 1'b0;

        // add 5+7
        din = op(3'b010, 32'd5, 32'd7); din.rw = 1'b1; tick();
        din = '0; tick();
        chk("add_alu", mem_aluout, 32'd12);
        chk("add_rw", {31'd0, mem_regwrite}, 32'd1);
        chk("add_valid", {31'd0, mem_valid}, 32'd1);

        // signed slt, then operands swapped
        din = op(3'b111, 32'hFFFF_FFFF, 32'd1); tick();
        din = op(3'b111, 32'd1, 32'hFFFF_FFFF); tick();
        chk("slt_neg", mem_aluout, 32'd1);
        din = '0; tick();
        chk("slt_swap", mem_aluout, 32'd0);

        // beq taken, bne not taken
        din = op(3'b110, 32'd9, 32'd9); din.br = 1'b1; din.pc4 = 32'h100; din.imm = 32'd3; tick();
        din.bne = 1'b1; tick();
        chk("beq_pcsrc", {31'd0, mem_pcsrc}, 32'd1);
        chk("beq_target", mem_pcbranch, 32'h10C);
        din = '0; tick();
        chk("bne_pcsrc", {31'd0, mem_pcsrc}, 32'd0);
        chk("bne_target", mem_pcbranch, 32'h10C);

        // forwarding from MEM then WB into operand A
        din = op(3'b010, 32'd1, 32'd0); din.alusrc = 1'b1; din.imm = 32'd2; tick();
        fwd_a = 2'b10; mem_fwd = 32'd40; #1;
        chk("fwd_rs_val", ex_rs_val_q, 32'd40);
        tick();
        chk("fwd_mem", mem_aluout, 32'd42);
        fwd_a = 2'b01; wb_fwd = 32'd8; din = '0; tick();
        chk("fwd_wb", mem_aluout, 32'd10);
        fwd_a = 2'b00;

        // stall one cycle: bubble first, held op next
        din = op(3'b010, 32'd1, 32'd2); din.rw = 1'b1; tick();
        stall_e = 1'b1; din = op(3'b011, 32'hF0, 32'h0F); tick();
        chk("stall_bubble_v", {31'd0, mem_valid}, 32'd0);
        chk("stall_bubble_rw", {31'd0, mem_regwrite}, 32'd0);
        stall_e = 1'b0; din = '0; tick();
        chk("stall_held_v", {31'd0, mem_valid}, 32'd1);
        chk("stall_held_alu", mem_aluout, 32'd3);

        // flush the store entering EX
        din = op(3'b010, 32'd4, 32'd4); din.mw = 1'b1; flush_e = 1'b1; tick();
        flush_e = 1'b0; din = '0; tick();
        chk("flush_v", {31'd0, mem_valid}, 32'd0);
        chk("flush_mw", {31'd0, mem_memwrite}, 32'd0);

        // illegal opcodes
        din = op(3'b100, 32'd3, 32'd3); tick();
        din = op(3'b101, 32'd3, 32'd3); din.valid = 1'b0; tick();
        chk("ill_flag", {31'd0, mem_illegal}, 32'd1);
        chk("ill_alu", mem_aluout, 32'd0);
        din = '0; tick();
        chk("ill_invalid", {31'd0, mem_illegal}, 32'd0);

        // reset with both registers holding valid regwrite ops
        din = op(3'b001, 32'd6, 32'd1); din.rw = 1'b1; tick();
        tick();
        chk("prerst_v", {31'd0, mem_valid}, 32'd1);
        reset = 1'b1; tick();
        chk("midrst_v", {31'd0, mem_valid}, 32'd0);
        chk("midrst_rw", {31'd0, mem_regwrite}, 32'd0);
        chk("midrst_alu", mem_aluout, 32'd0);
        reset = 1'b0; din = '0; tick();
        chk("midrst_idex", {31'd0, mem_valid}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            din.valid  = ($urandom_range(0, 3) != 0);
            din.ctl    = 3'($urandom_range(0, 7));
            din.alusrc = 1'($urandom_range(0, 1));
            din.rw     = 1'($urandom_range(0, 1));
            din.mw     = 1'($urandom_range(0, 1));
            din.mtr    = 1'($urandom_range(0, 1));
            din.br     = 1'($urandom_range(0, 1));
            din.bne    = 1'($urandom_range(0, 1));
            din.rd1    = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
            din.rd2    = ($urandom_range(0, 2) == 0) ? din.rd1 : $urandom;
            din.imm    = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
            din.wr     = 5'($urandom_range(0, 31));
            din.pc4    = $urandom;
            fwd_a      = 2'($urandom_range(0, 3));
            fwd_b      = 2'($urandom_range(0, 3));
            mem_fwd    = ($urandom_range(0, 3) == 0) ? din.rd1 : $urandom;
            wb_fwd     = $urandom;
            stall_e    = ($urandom_range(0, 9) == 0);
            flush_e    = ($urandom_range(0, 9) == 0);
            reset      = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
